// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RISC-V pipeline: operand forwarding, ALU,
// branch resolution and the EX/MEM pipeline register.
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [4:0]  RD_E,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic        regWrite_q, regWrite_d;
  logic        memWrite_q, memWrite_d;
  logic        resultSrc_q, resultSrc_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] aluResult_q, aluResult_d;
  logic [31:0] writeData_q, writeData_d;
  logic [31:0] pcPlus4_q, pcPlus4_d;

  logic [31:0] srcA, fwdB, srcB, aluResult;
  logic        zeroE;

  // Memory stage is younger than writeback, so it wins; x0 is never forwarded.
  always_comb begin
    srcA = RD1_E;
    if (regWrite_q && (rd_q != 5'd0) && (rd_q == RS1_E))
      srcA = aluResult_q;
    else if (RegWriteW && (RDW != 5'd0) && (RDW == RS1_E))
      srcA = ResultW;

    fwdB = RD2_E;
    if (regWrite_q && (rd_q != 5'd0) && (rd_q == RS2_E))
      fwdB = aluResult_q;
    else if (RegWriteW && (RDW != 5'd0) && (RDW == RS2_E))
      fwdB = ResultW;

    srcB = ALUSrcE ? Imm_Ext_E : fwdB;
  end

  always_comb begin
    aluResult = 32'd0;
    case (ALUControlE)
      3'b000:  aluResult = srcA + srcB;
      3'b001:  aluResult = srcA - srcB;
      3'b010:  aluResult = srcA & srcB;
      3'b011:  aluResult = srcA | srcB;
      3'b101:  aluResult = {31'd0, ($signed(srcA) < $signed(srcB))};
      default: aluResult = 32'd0;
    endcase
  end

  assign zeroE     = (aluResult == 32'd0);
  assign PCSrcE    = BranchE & zeroE;
  assign PCTargetE = PCE + Imm_Ext_E;

  // Store data is taken before the immediate mux so stores see forwarded values.
  always_comb begin
    regWrite_d  = RegWriteE;
    memWrite_d  = MemWriteE;
    resultSrc_d = ResultSrcE;
    rd_d        = RD_E;
    aluResult_d = aluResult;
    writeData_d = fwdB;
    pcPlus4_d   = PCPlus4E;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite_q  <= 1'b0;
      memWrite_q  <= 1'b0;
      resultSrc_q <= 1'b0;
      rd_q        <= 5'd0;
      aluResult_q <= 32'd0;
      writeData_q <= 32'd0;
      pcPlus4_q   <= 32'd0;
    end else begin
      regWrite_q  <= regWrite_d;
      memWrite_q  <= memWrite_d;
      resultSrc_q <= resultSrc_d;
      rd_q        <= rd_d;
      aluResult_q <= aluResult_d;
      writeData_q <= writeData_d;
      pcPlus4_q   <= pcPlus4_d;
    end
  end

  assign RegWriteM  = regWrite_q;
  assign MemWriteM  = memWrite_q;
  assign ResultSrcM = resultSrc_q;
  assign RD_M       = rd_q;
  assign ALUResultM = aluResult_q;
  assign WriteDataM = writeData_q;
  assign PCPlus4M   = pcPlus4_q;

endmodule
